// File: rtl/block_splitter.sv
// Byte-serialising splitter: takes whole BLOCK_BYTES-byte blocks and emits them one byte per cycle.
// Optional `BLOCK_SPLITTER_LAST_EN adds data_last, marking the final byte of the final block.
module block_splitter #(
  parameter int DATA_SIZE    = 8,
  parameter int BLOCK_BYTES  = 64,
  parameter int NUM_MATRICES = 20,
  localparam int BW = DATA_SIZE * BLOCK_BYTES,
  localparam int IW = $clog2(BLOCK_BYTES),
  localparam int CW = $clog2(NUM_MATRICES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BW-1:0]        blk_in,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [CW-1:0]        blk_count,
  output logic                 empty,
  output logic                 done,
`ifdef BLOCK_SPLITTER_LAST_EN
  output logic                 data_last,
`endif
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a channel only in a cycle where its
  // valid and ready are both high at the rising edge of clk.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] blk_reg;
  logic [IW-1:0] byte_idx;
  logic          ld_blk, inc_idx, inc_cnt;
  logic          last_byte, more_blocks;

  assign last_byte   = (byte_idx == IW'(BLOCK_BYTES - 1));
  assign more_blocks = (blk_count < CW'(NUM_MATRICES - 1));
  assign state_dbg   = state;

  always_comb begin
    state_nxt  = state;
    ld_blk     = 1'b0;
    inc_idx    = 1'b0;
    inc_cnt    = 1'b0;
    blk_ready  = 1'b0;
    data_valid = 1'b0;
    empty      = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          ld_blk    = 1'b1;
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        data_valid = 1'b1;
        empty      = 1'b0;
        if (data_ready) begin
          if (!last_byte) begin
            inc_idx = 1'b1;
          end else begin
            inc_cnt = 1'b1;
            if (!more_blocks) begin
              state_nxt = S_DONE;
            end else begin
              // Ready opens only on the last-byte transfer so the next block chains without a bubble.
              blk_ready = 1'b1;
              if (blk_valid) ld_blk = 1'b1;
              else           state_nxt = S_IDLE;
            end
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign data_out = (state == S_EMIT) ? blk_reg[int'(byte_idx) * DATA_SIZE +: DATA_SIZE]
                                      : '0;

`ifdef BLOCK_SPLITTER_LAST_EN
  assign data_last = (state == S_EMIT) && last_byte && !more_blocks;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      blk_reg   <= '0;
      byte_idx  <= '0;
      blk_count <= '0;
    end else begin
      state <= state_nxt;
      if (ld_blk) begin
        blk_reg  <= blk_in;
        byte_idx <= '0;
      end else if (inc_idx) begin
        byte_idx <= byte_idx + IW'(1);
      end
      if (inc_cnt) blk_count <= blk_count + CW'(1);
    end
  end

endmodule

// File: doc/block_splitter.md
# block_splitter

Byte-serialising splitter: accepts whole 64-byte ChaCha20 blocks (keystream or ciphertext) on a wide parallel bus and emits them one `DATA_SIZE`-bit byte per cycle under a valid/ready handshake. It is the inverse of the byte concatenator: the concatenator packs a byte stream into a `64*NUM_MATRICES`-byte buffer, and this block unpacks blocks back into a byte stream. It counts blocks up to `NUM_MATRICES` and then stops accepting input. Its typical uses are feeding the Poly1305 byte path and the output port of the AEAD.

## Interface
- `DATA_SIZE`, 8: output byte width.
- `BLOCK_BYTES`, 64: bytes per input block; input bus width is `DATA_SIZE*BLOCK_BYTES`.
- `NUM_MATRICES`, 20: blocks per message; after this many blocks have been emitted the block is done.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `blk_in` in `DATA_SIZE*BLOCK_BYTES`: input block; byte 0 = bits `[DATA_SIZE-1:0]`, byte k = bits `[DATA_SIZE*k +: DATA_SIZE]`.
- `blk_valid` in 1: `blk_in` is valid.
- `blk_ready` out 1: the block can accept `blk_in` this cycle.
- `data_out` out `DATA_SIZE`: current output byte.
- `data_valid` out 1: `data_out` is valid.
- `data_ready` in 1: downstream accepts `data_out` this cycle.
- `blk_count` out `$clog2(NUM_MATRICES+1)`: number of blocks fully emitted.
- `empty` out 1: no block is held.
- `done` out 1: `NUM_MATRICES` blocks have been emitted; sticky until `rst`.

## Operation
- Handshakes:
  - An input transfer occurs when `blk_valid & blk_ready`.
  - An output transfer occurs when `data_valid & data_ready`.
- The FSM has three states: IDLE, EMIT, DONE.
- **IDLE**
  - Outputs: `blk_ready=1`, `data_valid=0`, `empty=1`.
  - On an input transfer: capture `blk_in` into the block register, set `byte_idx=0`, go to EMIT.
- **EMIT**
  - Outputs: `data_valid=1`, `empty=0`, `data_out = byte[byte_idx]`.
  - On an output transfer with `byte_idx < BLOCK_BYTES-1`: increment `byte_idx`.
  - On an output transfer with `byte_idx == BLOCK_BYTES-1`: increment `blk_count`. Then:
    - If the new count equals `NUM_MATRICES`, go to DONE.
    - Otherwise, if `blk_valid`, capture the next block, reset `byte_idx` to 0 and stay in EMIT (gap-free chaining).
    - Otherwise, go to IDLE.
  - `blk_ready` is 1 in EMIT only in a cycle that contains the last-byte output transfer and where `blk_count+1 < NUM_MATRICES`. This is a combinational path from `data_ready`.
- **DONE**
  - Outputs: `blk_ready=0`, `data_valid=0`, `empty=1`, `done=1`.
  - `blk_valid` is ignored. The FSM leaves DONE only on `rst`.
- Stability: while `data_valid & !data_ready`, `data_out` and `byte_idx` hold. Input bytes are never dropped or duplicated.
- `byte_idx` is `$clog2(BLOCK_BYTES)` bits wide and never exceeds `BLOCK_BYTES-1`.
- `blk_count` saturates at `NUM_MATRICES` (it cannot increment from DONE).

## Timing
- Reset values (applied one cycle after `rst` is sampled high):
  - State = IDLE.
  - `blk_ready=1`, `data_valid=0`, `data_out=0`, `blk_count=0`, `empty=1`, `done=0`.
  - The block register is cleared.
- Reset mid-operation: the block in progress is discarded and the count returns to 0. `rst` takes priority over every handshake in the same cycle.
- Latency: a block accepted at edge N presents byte 0 with `data_valid=1` after edge N (in cycle N+1).
- Throughput:
  - With `data_ready` held high, one byte per cycle.
  - A single block takes `BLOCK_BYTES` cycles.
  - With `blk_valid` held high and chaining, `NUM_MATRICES*BLOCK_BYTES` consecutive valid cycles, with no bubbles.
- Timing of `done`:
  - `done` rises the cycle after the last byte of block `NUM_MATRICES` transfers.
  - `data_valid` falls in that same cycle.

## Configuration
- `BLOCK_SPLITTER_LAST_EN`
  - Defined: adds output port `data_last` (1 bit). It is high with `data_valid` on byte `BLOCK_BYTES-1` of block `NUM_MATRICES`, is 0 otherwise, and resets to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `blk_valid=1` → `blk_ready=1`, `data_valid=0`, `data_out=0`, `blk_count=0`, `empty=1`, `done=0`.
- **Single block:** `blk_in` bytes = `k+8'h10` for k=0..63, `data_ready=1` → bytes `8'h10`..`8'h4F` appear on 64 consecutive cycles starting 1 cycle after acceptance. After that `blk_count=1`, `empty=1`, state is IDLE.
- **Backpressure:** toggle `data_ready` randomly during a block whose byte k = k → the accepted byte sequence is exactly 0..63. `data_out` is stable across every stalled cycle.
- **Full message:** `blk_valid` held high, `data_ready=1`, `NUM_MATRICES=20` → 1280 contiguous valid bytes with no bubble. Then `done=1`, `blk_count=20`, `blk_ready=0`. A further `blk_valid` is ignored. With `BLOCK_SPLITTER_LAST_EN` defined, `data_last` pulses on byte 1279 only.
- **Reset mid-block:** assert `rst` at byte 30 of block 5 → the next cycle shows `data_valid=0` and `blk_count=0`. A fresh block with every byte `8'h07` then emits 64 × `8'h07`.
- **Chaining boundary:** the last-byte transfer and `blk_valid` occur in the same cycle → the next block is accepted in that cycle, and its byte 0 appears in the following cycle with no gap.
